// File: rtl/add_round_key_pkg.sv
// Shared types and helpers for the AES AddRoundKey stage.
package add_round_key_pkg;

  localparam int unsigned BLOCK_W  = 128;
  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned COL_W    = 32;

  typedef logic [BLOCK_W-1:0] aes_block_t;
  typedef logic [COL_W-1:0]   aes_col_t;

  // Even-parity bit: set when the byte holds an odd number of ones.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/add_key_column.sv
// One 32-bit state column XORed with its key column.
// With ADD_ROUND_KEY_PARITY_EN: per-byte output parity and a key parity check.
module add_key_column
  import add_round_key_pkg::*;
(
  input  aes_col_t   colIn,
  input  aes_col_t   colKey,
  output aes_col_t   colOut
`ifdef ADD_ROUND_KEY_PARITY_EN
  ,
  input  logic [3:0] keyPar,
  output logic [3:0] colPar,
  output logic       keyParBad
`endif
);

  assign colOut = colIn ^ colKey;

`ifdef ADD_ROUND_KEY_PARITY_EN
  logic [3:0] keyParCalc;

  // Bit 3 covers the column's top byte [31:24].
  always_comb begin
    colPar     = '0;
    keyParCalc = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      colPar[b]     = byte_parity(colOut[8*b +: 8]);
      keyParCalc[b] = byte_parity(colKey[8*b +: 8]);
    end
  end

  assign keyParBad = |(keyParCalc ^ keyPar);
`endif

endmodule

// File: rtl/add_round_key.sv
// AES AddRoundKey with a one-deep valid/ready output register (REG_OUT=1)
// or a combinational pass-through (REG_OUT=0). Optional macro: ADD_ROUND_KEY_PARITY_EN.
module add_round_key #(
  parameter int REG_OUT = 1,
  parameter int BLOCK_W = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] keyed_in,
  input  logic [BLOCK_W-1:0] key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] keyed_out
`ifdef ADD_ROUND_KEY_PARITY_EN
  ,
  output logic [15:0]        keyed_out_par,
  input  logic [15:0]        key_par,
  output logic               err_key_par
`endif
);

  import add_round_key_pkg::*;

  if (BLOCK_W != 128) begin : gBadWidth
    $error("add_round_key: only BLOCK_W=128 is supported");
  end

  logic [BLOCK_W-1:0] xorRes;
  logic               inXfer;
`ifdef ADD_ROUND_KEY_PARITY_EN
  logic [15:0]        parRes;
  logic [3:0]         colKeyBad;
`endif

  // Column c spans bits [127-32c -: 32]; parity nibble c spans [15-4c -: 4].
  for (genvar c = 0; c < NUM_COLS; c++) begin : gCol
    add_key_column uCol (
      .colIn    (keyed_in[BLOCK_W-1-COL_W*c -: COL_W]),
      .colKey   (key[BLOCK_W-1-COL_W*c -: COL_W]),
      .colOut   (xorRes[BLOCK_W-1-COL_W*c -: COL_W])
`ifdef ADD_ROUND_KEY_PARITY_EN
      ,
      .keyPar   (key_par[15-4*c -: 4]),
      .colPar   (parRes[15-4*c -: 4]),
      .keyParBad(colKeyBad[c])
`endif
    );
  end

  if (REG_OUT != 0) begin : gReg
    logic               outValidQ;
    logic [BLOCK_W-1:0] outQ;

    assign in_ready  = !outValidQ || out_ready;
    assign inXfer    = in_valid && in_ready;
    assign out_valid = outValidQ;
    assign keyed_out = outQ;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        outValidQ <= 1'b0;
        outQ      <= '0;
      end else if (inXfer) begin
        outValidQ <= 1'b1;
        outQ      <= xorRes;
      end else if (out_ready) begin
        outValidQ <= 1'b0;
      end
    end

`ifdef ADD_ROUND_KEY_PARITY_EN
    logic [15:0] parQ;

    assign keyed_out_par = parQ;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)         parQ <= '0;
      else if (inXfer) parQ <= parRes;
    end
`endif
  end else begin : gComb
    assign in_ready  = out_ready;
    assign inXfer    = in_valid && out_ready;
    assign out_valid = in_valid;
    assign keyed_out = xorRes;
`ifdef ADD_ROUND_KEY_PARITY_EN
    assign keyed_out_par = parRes;
`endif
  end

`ifdef ADD_ROUND_KEY_PARITY_EN
  // The sticky error flag stays clocked even in pass-through mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      err_key_par <= 1'b0;
    else if (inXfer && |colKeyBad) err_key_par <= 1'b1;
  end
`else
  logic unusedIn;
  assign unusedIn = inXfer;
`endif

endmodule

// File: tb/tb_add_round_key.sv
// Scoreboard bench for add_round_key: driver pushes expected blocks, monitor pops on output transfer.
module tb_add_round_key;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] keyed_in;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] keyed_out;
`ifdef ADD_ROUND_KEY_PARITY_EN
  logic [15:0]  keyed_out_par;
  logic [15:0]  key_par;
  logic         err_key_par;
  logic [15:0]  parFlip = '0;
  logic [15:0]  parQ[$];
`endif

  add_round_key #(.REG_OUT(1), .BLOCK_W(128)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .keyed_in     (keyed_in),
    .key          (key),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .keyed_out    (keyed_out)
`ifdef ADD_ROUND_KEY_PARITY_EN
    ,
    .keyed_out_par(keyed_out_par),
    .key_par      (key_par),
    .err_key_par  (err_key_par)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [127:0] FIPS_IN  = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] FIPS_KEY = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] FIPS_OUT = 128'ha49c7ff2_689f352b_6b5bea43_026a5049;
  localparam logic [127:0] ONES     = {128{1'b1}};

  int          checks = 0;
  int          fails  = 0;
  longint      cycle  = 0;
  logic [127:0] expQ[$];
  longint      popCyc[$];

  always @(posedge clk) cycle <= cycle + 1;

  // Reference: sixteen independent byte XORs, assembled arithmetically.
  function automatic logic [127:0] refXor(input logic [127:0] a, input logic [127:0] k);
    logic [127:0] r = '0;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] ab = 8'((a >> (8 * i)) & 128'hff);
      logic [7:0] kb = 8'((k >> (8 * i)) & 128'hff);
      r = r | (128'(ab ^ kb) << (8 * i));
    end
    return r;
  endfunction

  function automatic logic [15:0] refPar(input logic [127:0] v);
    logic [15:0] p = '0;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b = 8'((v >> (8 * i)) & 128'hff);
      p[i] = ($countones(b) % 2) == 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_output: got %h expected none", keyed_out);
      end else begin
        chk("scoreboard", keyed_out, expQ.pop_front());
        popCyc.push_back(cycle);
`ifdef ADD_ROUND_KEY_PARITY_EN
        chk("scoreboard_par", 128'(keyed_out_par), 128'(parQ.pop_front()));
`endif
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the block.
  task automatic send(input logic [127:0] d, input logic [127:0] k, input logic [127:0] exp);
    logic rdy;
    bit   ok = 0;
    in_valid = 1'b1;
    keyed_in = d;
    key      = k;
`ifdef ADD_ROUND_KEY_PARITY_EN
    key_par  = refPar(k) ^ parFlip;
`endif
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        expQ.push_back(exp);
`ifdef ADD_ROUND_KEY_PARITY_EN
        parQ.push_back(refPar(exp));
`endif
        ok = 1;
      end
    end
    #1;
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL send_timeout: got in_ready=0 expected acceptance within 50 cycles");
    end
  endtask

  initial begin
    int base;
    rst       = 1'b1;
    in_valid  = 1'b1;
    keyed_in  = FIPS_IN;
    key       = FIPS_KEY;
    out_ready = 1'b1;
`ifdef ADD_ROUND_KEY_PARITY_EN
    key_par   = '0;
`endif
    // Two clock edges pass with in_valid high; nothing may be captured.
    #17;
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_keyed_out", keyed_out, '0);
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;

    send(FIPS_IN, FIPS_KEY, FIPS_OUT);
    send(FIPS_IN, '0, FIPS_IN);
    send(ONES, ONES, '0);
    send(FIPS_OUT, FIPS_KEY, FIPS_IN);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Back-pressure: output must freeze while downstream stalls.
    out_ready = 1'b0;
    send(FIPS_IN, FIPS_KEY, FIPS_OUT);
    for (int i = 0; i < 5; i++) begin
      keyed_in = rnd128();
      @(negedge clk);
      chk("stall_keyed_out", keyed_out, FIPS_OUT);
      chk("stall_out_valid", 128'(out_valid), 128'(1));
      chk("stall_in_ready", 128'(in_ready), 128'(0));
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("drain_out_valid", 128'(out_valid), 128'(0));
    @(posedge clk); #1;

    // Streaming: eight blocks back to back must leave on eight consecutive cycles.
    base = popCyc.size();
    for (int i = 0; i < 8; i++) begin
      logic [127:0] a = rnd128();
      logic [127:0] k = rnd128();
      send(a, k, refXor(a, k));
    end
    in_valid = 1'b0;
    for (int n = 0; n < 20 && expQ.size() != 0; n++) @(posedge clk);
    #1;
    chk("stream_count", 128'(popCyc.size() - base), 128'(8));
    if (popCyc.size() - base == 8)
      chk("stream_no_bubble", 128'(popCyc[base+7] - popCyc[base]), 128'(7));

    // Random traffic against random downstream stalls.
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          logic [127:0] a = rnd128();
          logic [127:0] k = rnd128();
          send(a, k, refXor(a, k));
          in_valid = ($urandom % 4) != 0;
          if (!in_valid) begin
            @(posedge clk); #1;
          end
        end
        in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 60; i++) begin
          @(posedge clk); #1;
          out_ready = ($urandom % 3) != 0;
        end
      end
    join
    out_ready = 1'b1;
    for (int n = 0; n < 20 && expQ.size() != 0; n++) @(posedge clk);
    #1;
    chk("random_drained", 128'(expQ.size()), 128'(0));

    // Asynchronous reset between edges while a block is stalled.
    out_ready = 1'b0;
    send(FIPS_IN, FIPS_KEY, FIPS_OUT);
    in_valid = 1'b0;
    @(posedge clk); #2;
    chk("pre_reset_valid", 128'(out_valid), 128'(1));
    rst = 1'b1;
    #1;
    chk("async_reset_valid", 128'(out_valid), 128'(0));
    chk("async_reset_data", keyed_out, '0);
    chk("async_reset_in_ready", 128'(in_ready), 128'(1));
    expQ.delete();
`ifdef ADD_ROUND_KEY_PARITY_EN
    parQ.delete();
`endif
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(ONES, FIPS_KEY, refXor(ONES, FIPS_KEY));
    in_valid = 1'b0;

`ifdef ADD_ROUND_KEY_PARITY_EN
    @(negedge clk);
    chk("par_err_clear", 128'(err_key_par), 128'(0));
    @(posedge clk); #1;
    send(FIPS_IN, FIPS_KEY, FIPS_OUT);
    in_valid = 1'b0;
    @(negedge clk);
    chk("par_fips_bit15", 128'(keyed_out_par[15]), 128'(1));
    chk("par_err_good_key", 128'(err_key_par), 128'(0));
    @(posedge clk); #1;
    parFlip = 16'h0100;
    send(FIPS_IN, FIPS_KEY, FIPS_OUT);
    parFlip  = '0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("par_err_set", 128'(err_key_par), 128'(1));
    repeat (3) @(posedge clk);
    #1;
    chk("par_err_sticky", 128'(err_key_par), 128'(1));
    rst = 1'b1;
    #1;
    chk("par_err_reset", 128'(err_key_par), 128'(0));
    rst = 1'b0;
    expQ.delete();
    parQ.delete();
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("final_queue_empty", 128'(expQ.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/add_round_key.md
Name: add_round_key

Overview:
- AES AddRoundKey stage: bitwise XOR of a 128-bit cipher state with a 128-bit round key.
- Sits between MixColumns (or the input whitening step) and the next round in the Rijndael datapath.
- Wrapped in a one-deep valid/ready output register so it drops into the pipelined round chain.

Parameters:
- REG_OUT, 1, 1 = registered output with 1-cycle latency; 0 = combinational pass-through with the handshake wired straight through.
- BLOCK_W, 128, state/key width; only 128 is supported and must be enforced with an elaboration-time check.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  keyed_in/key are valid this cycle.
- in_ready  out  1  stage can accept input.
- keyed_in  in  128  cipher state; byte 0 = [127:120] (FIPS-197 column-major order).
- key  in  128  round key, same byte order.
- out_valid  out  1  keyed_out is valid.
- out_ready  in  1  downstream accepts.
- keyed_out  out  128  keyed_in XOR key.

Behaviour:
- Arithmetic: keyed_out[i] = keyed_in[i] ^ key[i] for all 128 bits. No carries and no byte reordering.
- REG_OUT=1 timing:
  - Input transfer occurs when in_valid && in_ready.
  - in_ready = !out_valid || out_ready.
  - On transfer, the XOR result is registered into keyed_out and out_valid is set on the next clk edge (latency 1).
  - Output transfer occurs when out_valid && out_ready. If there is no new input transfer in the same cycle, out_valid clears.
  - Simultaneous output and input transfer: the register reloads with the new result and out_valid stays 1, giving full throughput of 1 block/cycle.
  - Stall: while out_valid && !out_ready, keyed_out and out_valid must hold stable. in_ready stays 0.
- Reset: rst asserted, at any time including mid-transfer, forces out_valid=0 and keyed_out=0 asynchronously. In-flight data is discarded.
  - in_ready=1 during reset, but no transfer is captured while rst is high.
- REG_OUT=0 timing:
  - keyed_out = keyed_in ^ key combinationally.
  - out_valid = in_valid.
  - in_ready = out_ready.
  - clk and rst are unused.
- X-handling: keyed_out may follow X inputs only when in_valid=0. The register must load only on transfer.

Optional Feature:
- Macro: ADD_ROUND_KEY_PARITY_EN.
- When defined:
  - Extra output port keyed_out_par [15:0], one even-parity bit per byte. Bit 15 covers byte [127:120]; bit 0 covers [7:0].
  - Registered/timed identically to keyed_out, and reset to 0.
  - Extra input key_par [15:0] giving the expected per-byte parity of key.
  - Output err_key_par is asserted in the cycle following a transfer whose key parity mismatches. It is sticky until rst.
- When undefined: these ports and their logic do not exist. The main datapath is unchanged.

Decomposition:
- Package add_round_key_pkg:
  - BLOCK_W=128, NUM_COLS=4, COL_W=32.
  - typedef aes_block_t (logic [127:0]) and aes_col_t (logic [31:0]).
  - Function byte_parity.
- One natural sub-module: add_key_column, a 32-bit column XOR instantiated 4 times (columns 0..3 = bits [127:96]..[31:0]). The parity option adds 4 parity bits per column inside it.

Test Plan:
- FIPS-197 round-1 vector: keyed_in=046681e5_e0cb199a_48f8d37a_2806264c, key=a0fafe17_88542cb1_23a33939_2a6c7605, in_valid=1, out_ready=1 -> one cycle later out_valid=1, keyed_out=a49c7ff2_689f352b_6b5bea43_026a5049.
- Identity and self-inverse:
  - key=0 -> keyed_out=keyed_in.
  - keyed_in=key=ffffffff_ffffffff_ffffffff_ffffffff -> keyed_out=0.
  - Feeding the output back with the same key restores 046681e5_e0cb199a_48f8d37a_2806264c.
- Back-pressure: load the FIPS vector, hold out_ready=0 for 5 cycles while changing keyed_in -> keyed_out stays a49c7ff2..., in_ready=0. Release out_ready -> transfer, out_valid drops next cycle.
- Streaming: 8 consecutive random blocks with out_ready=1 -> 8 outputs on 8 consecutive cycles, each equal to the reference XOR, with no bubbles.
- Async reset mid-stall: assert rst between clock edges while out_valid=1 -> out_valid=0 and keyed_out=0 immediately, with no clk edge required.
- With ADD_ROUND_KEY_PARITY_EN: FIPS vector -> keyed_out_par bit15 = parity(a4)=1. Wrong key_par bit -> err_key_par=1 and held until rst.
